// File: rtl/regfile_wb_arbiter.sv
// Merges ALU writeback (absolute priority) and buffered MDU results onto the single register-file write port.
// Port outputs are registered one cycle after selection; MDU is held off via mdu_ready while its FIFO is full.

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // carries the extra bit that tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_we,
  input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_wd,
  input  logic                        mdu_issue,
  input  logic [ADDRESS_WIDTH-1:0]    mdu_issue_rd,
  input  logic                        mdu_valid,
  output logic                        mdu_ready,
  input  logic [ADDRESS_WIDTH-1:0]    mdu_rd,
  input  logic [DATA_WIDTH-1:0]       mdu_wd,
  output logic                        WE3,
  output logic [ADDRESS_WIDTH-1:0]    AD3,
  output logic [DATA_WIDTH-1:0]       WD3,
  output logic [2**ADDRESS_WIDTH-1:0] busy
);
  localparam int NREG = 2**ADDRESS_WIDTH;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    wd;
  } wb_t;

  wb_t w_mdu_dat;
  wb_t w_head_dat;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_xfer;
  logic w_pop;
  logic w_push;
  logic w_bypass;
  logic w_load;
  logic w_mdu_sel;
  logic [ADDRESS_WIDTH-1:0] w_sel_rd;
  logic [DATA_WIDTH-1:0]    w_sel_wd;
  logic [NREG-1:0]          w_busy_nxt;

  logic                     r_we3;
  logic [ADDRESS_WIDTH-1:0] r_ad3;
  logic [DATA_WIDTH-1:0]    r_wd3;
  logic [NREG-1:0]          r_busy;

  assign w_mdu_dat = '{rd: mdu_rd, wd: mdu_wd};
  assign mdu_ready = !w_fifo_full;
  assign w_xfer    = mdu_valid && mdu_ready;

  always_comb begin
    w_load    = 1'b0;
    w_pop     = 1'b0;
    w_bypass  = 1'b0;
    w_mdu_sel = 1'b0;
    w_sel_rd  = r_ad3;
    w_sel_wd  = r_wd3;
    if (alu_we) begin
      w_load   = 1'b1;
      w_sel_rd = alu_rd;
      w_sel_wd = alu_wd;
    end else if (!w_fifo_empty) begin
      w_load    = 1'b1;
      w_pop     = 1'b1;
      w_mdu_sel = 1'b1;
      w_sel_rd  = w_head_dat.rd;
      w_sel_wd  = w_head_dat.wd;
    end else if (w_xfer) begin
      w_load    = 1'b1;
      w_bypass  = 1'b1;
      w_mdu_sel = 1'b1;
      w_sel_rd  = mdu_rd;
      w_sel_wd  = mdu_wd;
    end
  end

  assign w_push = w_xfer && !w_bypass;

  fifo #(
    .WIDTH ($bits(wb_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_mdu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_mdu_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head_dat),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Issue is applied after clear so a same-cycle re-issue keeps the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_mdu_sel) w_busy_nxt[w_sel_rd] = 1'b0;
    if (mdu_issue) w_busy_nxt[mdu_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3  <= 1'b0;
      r_ad3  <= '0;
      r_wd3  <= '0;
      r_busy <= '0;
    end else begin
      r_we3  <= w_load && (w_sel_rd != '0);
      r_ad3  <= w_sel_rd;
      r_wd3  <= w_sel_wd;
      r_busy <= w_busy_nxt;
    end
  end

  assign WE3  = r_we3;
  assign AD3  = r_ad3;
  assign WD3  = r_wd3;
  assign busy = r_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench for regfile_wb_arbiter: ALU and MDU writes are queued when driven/accepted
// and popped as the write port fires; directed checks cover reset, hazards and backpressure.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wd;
  logic        WE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;
  logic [31:0] busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] alu_q[$];
  logic [36:0] mdu_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32),
    .FIFO_DEPTH    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_we       (alu_we),
    .alu_rd       (alu_rd),
    .alu_wd       (alu_wd),
    .mdu_issue    (mdu_issue),
    .mdu_issue_rd (mdu_issue_rd),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_rd       (mdu_rd),
    .mdu_wd       (mdu_wd),
    .WE3          (WE3),
    .AD3          (AD3),
    .WD3          (WD3),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record what should be written, advance, then score the port.
  task automatic cycle();
    logic        alu_now;
    logic [36:0] e;
    alu_now = !rst && alu_we && (alu_rd != 5'd0);
    if (!rst && mdu_valid && mdu_ready && (mdu_rd != 5'd0))
      mdu_q.push_back({mdu_rd, mdu_wd});
    if (alu_now)
      alu_q.push_back({alu_rd, alu_wd});
    @(posedge clk);
    #1;
    if (alu_now) begin
      chk("alu_we3", {63'd0, WE3}, 64'd1);
      e = alu_q.pop_front();
      chk("alu_ad3", {59'd0, AD3}, {59'd0, e[36:32]});
      chk("alu_wd3", {32'd0, WD3}, {32'd0, e[31:0]});
    end else if (WE3) begin
      if (mdu_q.size() == 0) begin
        chk("unexpected_we3", {63'd0, WE3}, 64'd0);
      end else begin
        e = mdu_q.pop_front();
        chk("mdu_ad3", {59'd0, AD3}, {59'd0, e[36:32]});
        chk("mdu_wd3", {32'd0, WD3}, {32'd0, e[31:0]});
      end
    end
  endtask

  task automatic idle_inputs();
    alu_we = 1'b0; alu_rd = '0; alu_wd = '0;
    mdu_issue = 1'b0; mdu_issue_rd = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_wd = '0;
  endtask

  initial begin
    logic [4:0] mrd [3];
    logic [1:0] idx;
    logic       exp_rdy [6];
    mrd = '{5'd3, 5'd4, 5'd6};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    idle_inputs();

    // Reset dominates concurrent ALU and MDU activity.
    rst = 1'b1;
    alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'h11;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_wd = 32'h22;
    mdu_issue = 1'b1; mdu_issue_rd = 5'd8;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_we3", {63'd0, WE3}, 64'd0);
      chk("rst_busy", {32'd0, busy}, 64'd0);
    end
    rst = 1'b0;
    idle_inputs();
    chk("rst_ready", {63'd0, mdu_ready}, 64'd1);
    chk("rst_ad3", {59'd0, AD3}, 64'd0);
    cycle();
    chk("post_rst_we3", {63'd0, WE3}, 64'd0);

    // ALU only.
    alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    cycle();
    chk("alu_ad3_5", {59'd0, AD3}, 64'd5);
    chk("alu_wd3_dead", {32'd0, WD3}, 64'hDEADBEEF);
    alu_we = 1'b0;
    cycle();
    chk("alu_drop_we3", {63'd0, WE3}, 64'd0);

    // Bypass path clears the scoreboard bit on the writing edge.
    mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
    cycle();
    mdu_issue = 1'b0;
    chk("busy7_set", {63'd0, busy[7]}, 64'd1);
    cycle();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wd = 32'd42;
    chk("byp_ready", {63'd0, mdu_ready}, 64'd1);
    cycle();
    mdu_valid = 1'b0;
    chk("byp_we3", {63'd0, WE3}, 64'd1);
    chk("byp_ad3", {59'd0, AD3}, 64'd7);
    chk("byp_wd3", {32'd0, WD3}, 64'd42);
    chk("busy7_clr", {63'd0, busy[7]}, 64'd0);

    // Contention: four ALU writes while MDU results 3, 4, 6 queue up.
    for (int i = 0; i < 3; i++) begin
      mdu_issue = 1'b1; mdu_issue_rd = mrd[i];
      cycle();
    end
    mdu_issue = 1'b0;
    chk("busy_346", {32'd0, busy}, 64'h58);
    idx = 2'd0;
    for (int i = 0; i < 6; i++) begin
      alu_we = (i < 4);
      alu_rd = 5'(10 + i);
      alu_wd = 32'hA000 + i;
      mdu_valid = (idx < 2'd3);
      mdu_rd = (idx < 2'd3) ? mrd[idx] : 5'd0;
      mdu_wd = 32'h300 + {30'd0, idx};
      chk($sformatf("cont_ready_%0d", i), {63'd0, mdu_ready}, {63'd0, exp_rdy[i]});
      if (mdu_valid && mdu_ready) idx = idx + 2'd1;
      cycle();
      if (i >= 4) begin
        chk($sformatf("cont_we3_%0d", i), {63'd0, WE3}, 64'd1);
        chk($sformatf("cont_ad3_%0d", i), {59'd0, AD3}, {59'd0, mrd[i-4]});
      end
    end
    idle_inputs();
    cycle();
    chk("cont_ad3_last", {59'd0, AD3}, 64'd6);
    chk("cont_busy_clr", {32'd0, busy}, 64'd0);
    cycle();
    chk("cont_drain_we3", {63'd0, WE3}, 64'd0);

    // Register 0: never written, never busy, but still consumed.
    alu_we = 1'b1; alu_rd = 5'd0; alu_wd = 32'h123;
    cycle();
    chk("r0_alu_we3", {63'd0, WE3}, 64'd0);
    alu_we = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_wd = 32'h55;
    chk("r0_mdu_ready", {63'd0, mdu_ready}, 64'd1);
    cycle();
    chk("r0_mdu_we3", {63'd0, WE3}, 64'd0);
    mdu_valid = 1'b0;
    mdu_issue = 1'b1; mdu_issue_rd = 5'd0;
    cycle();
    mdu_issue = 1'b0;
    chk("r0_consumed_we3", {63'd0, WE3}, 64'd0);
    chk("r0_busy", {32'd0, busy}, 64'd0);
    chk("r0_ready", {63'd0, mdu_ready}, 64'd1);

    // Re-issue of rd 9 on the edge its queued result is written.
    mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
    cycle();
    mdu_issue = 1'b0;
    alu_we = 1'b1; alu_rd = 5'd20; alu_wd = 32'hCAFE;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h99;
    cycle();
    idle_inputs();
    mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
    cycle();
    mdu_issue = 1'b0;
    chk("setclr_we3", {63'd0, WE3}, 64'd1);
    chk("setclr_ad3", {59'd0, AD3}, 64'd9);
    chk("setclr_busy9", {63'd0, busy[9]}, 64'd1);
    cycle();
    chk("setclr_busy9_hold", {63'd0, busy[9]}, 64'd1);
    chk("setclr_idle_we3", {63'd0, WE3}, 64'd0);

    chk("alu_q_empty", 64'(alu_q.size()), 64'd0);
    chk("mdu_q_empty", 64'(mdu_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
